// File: rtl/prbs_pkg.sv
// prbs_pkg: shared definitions for the PRBS generator and checker.
//   chk_state_e  checker FSM states
//   PRBS7/15/23/31  standard tap masks (bit i set => state[i] feeds back)
//   lfsr_next    one Fibonacci step on a right-aligned state of up to 64 bits
package prbs_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } chk_state_e;

    localparam logic [6:0]  PRBS7  = 7'h60;          // x^7  + x^6  + 1
    localparam logic [14:0] PRBS15 = 15'h6000;       // x^15 + x^14 + 1
    localparam logic [22:0] PRBS23 = 23'h42_0000;    // x^23 + x^18 + 1
    localparam logic [30:0] PRBS31 = 31'h4800_0000;  // x^31 + x^28 + 1

    // Shift left, feedback into bit 0, then trim to 'width' bits.
    // For width == 64 the shifted mask wraps to zero and the subtraction
    // yields all ones, so no special case is needed.
    function automatic logic [63:0] lfsr_next(input logic [63:0] st,
                                              input logic [63:0] taps,
                                              input int unsigned width);
        logic [63:0] mask;
        mask = (64'd1 << width) - 64'd1;
        return ((st << 1) | {63'd0, ^(st & taps)}) & mask;
    endfunction

endpackage

// File: rtl/prbs_lfsr_chk.sv
// prbs_lfsr_chk: self-synchronising PRBS checker (built with PRBS_CHECKER_EN).
//   clk, rst_n   clock, asynchronous active-high reset
//   chk_in       serial bit under test, qualified by chk_valid
//   chk_locked   high while the FSM is in LOCK
//   chk_errs     saturating count of mismatches seen while locked
module prbs_lfsr_chk
    import prbs_pkg::*;
#(
    parameter int unsigned      WIDTH       = 31,
    parameter logic [WIDTH-1:0] TAPS        = WIDTH'(PRBS31),
    parameter int unsigned      LOSS_THRESH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        chk_in,
    input  logic        chk_valid,
    output logic        chk_locked,
    output logic [15:0] chk_errs
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned MW = $clog2(LOSS_THRESH + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);
    localparam logic [MW-1:0] MISS_LAST = MW'(LOSS_THRESH - 1);

    chk_state_e      st_q, st_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [MW-1:0]   miss_q, miss_d;
    logic [15:0]     errs_q, errs_d;
    logic            locked_q, locked_d;
    logic            pred;
    logic [63:0]     adv;

    always_comb begin
        st_d     = st_q;
        ref_d    = ref_q;
        cnt_d    = cnt_q;
        miss_d   = miss_q;
        errs_d   = errs_q;
        locked_d = locked_q;
        pred     = ^(ref_q & TAPS);
        adv      = lfsr_next(64'(ref_q), 64'(TAPS), WIDTH);
        if (chk_valid) begin
            case (st_q)
                SEARCH: begin
                    ref_d = {ref_q[WIDTH-2:0], chk_in};
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        st_d  = VERIFY;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                VERIFY: begin
                    ref_d = {ref_q[WIDTH-2:0], chk_in};
                    if (pred == chk_in) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_d    = '0;
                            miss_d   = '0;
                            st_d     = LOCK;
                            locked_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        cnt_d = '0;
                        st_d  = SEARCH;
                    end
                end
                LOCK: begin
                    // Free-run on the prediction so isolated errors do not
                    // corrupt the reference.
                    ref_d = adv[WIDTH-1:0];
                    if (pred != chk_in) begin
                        if (errs_q != 16'hFFFF) begin
                            errs_d = errs_q + 16'd1;
                        end
                        if (miss_q == MISS_LAST) begin
                            miss_d   = '0;
                            cnt_d    = '0;
                            st_d     = SEARCH;
                            locked_d = 1'b0;
                        end else begin
                            miss_d = miss_q + MW'(1);
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: begin
                    st_d     = SEARCH;
                    cnt_d    = '0;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            st_q     <= SEARCH;
            ref_q    <= '0;
            cnt_q    <= '0;
            miss_q   <= '0;
            errs_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            st_q     <= st_d;
            ref_q    <= ref_d;
            cnt_q    <= cnt_d;
            miss_q   <= miss_d;
            errs_q   <= errs_d;
            locked_q <= locked_d;
        end
    end

    assign chk_locked = locked_q;
    assign chk_errs   = errs_q;

endmodule

// File: rtl/prbs_lfsr_gen.sv
// prbs_lfsr_gen: Fibonacci LFSR PRBS generator, STEP bits per enabled cycle,
// with seed-load handshake and all-zero lock-up recovery.
// Optional checker compiled in with `define PRBS_CHECKER_EN.
//   clk, rst_n    clock, asynchronous reset (active HIGH despite the name)
//   en            advance STEP steps this cycle
//   load_valid/load_ready/load_data  seed load (load wins over en)
//   dout          bits of last enabled cycle, oldest in MSB
//   dout_valid    registered en (0 on a load cycle)
//   state         current LFSR register
//   lockup        sticky: zero state/seed was replaced by SEED
//   chk_*         checker ports (PRBS_CHECKER_EN only)
module prbs_lfsr_gen
    import prbs_pkg::*;
#(
    parameter int unsigned      WIDTH       = 31,
    parameter logic [WIDTH-1:0] TAPS        = WIDTH'(PRBS31),
    parameter logic [WIDTH-1:0] SEED        = WIDTH'(1),
    parameter int unsigned      STEP        = 1,
    parameter int unsigned      LOSS_THRESH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic [STEP-1:0]  dout,
    output logic             dout_valid,
    output logic [WIDTH-1:0] state,
    output logic             lockup
`ifdef PRBS_CHECKER_EN
    ,
    input  logic             chk_in,
    input  logic             chk_valid,
    output logic             chk_locked,
    output logic [15:0]      chk_errs
`endif
);

    if (SEED == '0) begin : g_seed_err
        $error("prbs_lfsr_gen: SEED must be non-zero");
    end
    if (WIDTH < 3 || WIDTH > 64) begin : g_width_err
        $error("prbs_lfsr_gen: WIDTH must be 3..64");
    end
    if (STEP < 1 || STEP > 8) begin : g_step_err
        $error("prbs_lfsr_gen: STEP must be 1..8");
    end
    if (LOSS_THRESH < 1) begin : g_thresh_err
        $error("prbs_lfsr_gen: LOSS_THRESH must be at least 1");
    end

    localparam logic [63:0] TAPS64 = 64'(TAPS);

    logic [WIDTH-1:0] state_q, state_d;
    logic [STEP-1:0]  dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             lockup_q, lockup_d;
    logic             load_ready_q;
    logic             load_fire;
    logic [63:0]      walk;
    logic [STEP-1:0]  step_bits;

    assign load_fire = load_valid & load_ready_q;

    // STEP single steps unrolled; first emitted bit lands in the MSB.
    always_comb begin
        walk      = 64'(state_q);
        step_bits = '0;
        for (int unsigned i = 0; i < STEP; i++) begin
            step_bits[STEP-1-i] = walk[WIDTH-1];
            walk = lfsr_next(walk, TAPS64, WIDTH);
        end
    end

    always_comb begin
        state_d      = state_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        lockup_d     = lockup_q;
        if (load_fire) begin
            if (load_data == '0) begin
                state_d  = SEED;
                lockup_d = 1'b1;
            end else begin
                state_d = load_data;
            end
        end else if (state_q == '0) begin
            state_d  = SEED;
            lockup_d = 1'b1;
        end else if (en) begin
            state_d      = walk[WIDTH-1:0];
            dout_d       = step_bits;
            dout_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q      <= SEED;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            lockup_q     <= 1'b0;
            load_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            lockup_q     <= lockup_d;
            load_ready_q <= 1'b1;
        end
    end

    assign state      = state_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign lockup     = lockup_q;
    assign load_ready = load_ready_q;

`ifdef PRBS_CHECKER_EN
    prbs_lfsr_chk #(
        .WIDTH      (WIDTH),
        .TAPS       (TAPS),
        .LOSS_THRESH(LOSS_THRESH)
    ) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .chk_in    (chk_in),
        .chk_valid (chk_valid),
        .chk_locked(chk_locked),
        .chk_errs  (chk_errs)
    );
`endif

endmodule

// File: tb/tb_prbs_lfsr_gen.sv
// Bench for prbs_lfsr_gen: default 31-bit/1-step instance plus a
// 7-bit/4-step PRBS7 instance, both checked every cycle against a
// sequence-recurrence model (b[n+W] = XOR of tapped earlier bits).
`timescale 1ns/1ps
module tb_prbs_lfsr_gen;
    import prbs_pkg::*;

    localparam logic [63:0] MT31 = (64'd1 << 30) | (64'd1 << 27);
    localparam logic [63:0] MT7  = (64'd1 << 6) | (64'd1 << 5);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        en = 1'b0, load_valid = 1'b0;
    logic [30:0] load_data = '0;
    logic        load_ready, dout_valid, lockup;
    logic [0:0]  dout;
    logic [30:0] state;

    logic        lv7 = 1'b0;
    logic [6:0]  ld7 = '0;
    logic        ready7, dv7, lock7;
    logic [3:0]  dout7;
    logic [6:0]  state7;

`ifdef PRBS_CHECKER_EN
    logic        chk_in = 1'b0, chk_valid = 1'b0;
    logic        chk_locked;
    logic [15:0] chk_errs;
    logic        chk7_in = 1'b0, chk7_valid = 1'b0;
    logic        chk7_locked;
    logic [15:0] chk7_errs;
`endif

    prbs_lfsr_gen dut (
        .clk(clk), .rst_n(rst), .en(en), .load_valid(load_valid),
        .load_ready(load_ready), .load_data(load_data), .dout(dout),
        .dout_valid(dout_valid), .state(state), .lockup(lockup)
`ifdef PRBS_CHECKER_EN
        , .chk_in(chk_in), .chk_valid(chk_valid),
        .chk_locked(chk_locked), .chk_errs(chk_errs)
`endif
    );

    prbs_lfsr_gen #(.WIDTH(7), .TAPS(PRBS7), .SEED(7'h01), .STEP(4)) dut7 (
        .clk(clk), .rst_n(rst), .en(en), .load_valid(lv7),
        .load_ready(ready7), .load_data(ld7), .dout(dout7),
        .dout_valid(dv7), .state(state7), .lockup(lock7)
`ifdef PRBS_CHECKER_EN
        , .chk_in(chk7_in), .chk_valid(chk7_valid),
        .chk_locked(chk7_locked), .chk_errs(chk7_errs)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    // Model: window w[k] = k-th oldest pending bit; state MSB is w[0].
    logic [63:0] m_w, m7_w;
    logic        m_dout, m_dv, m_lock, m_ready;
    logic [3:0]  m7_dout;
    logic        m7_dv, m7_lock, m7_ready;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rev(input logic [63:0] v, input int width);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < width; j++) r[j] = v[width-1-j];
        return r;
    endfunction

    function automatic void adv(input logic [63:0] w_in, input logic [63:0] taps,
                                input int width, input int steps,
                                output logic [63:0] w_out, output logic [7:0] bits);
        logic [63:0] w;
        logic        nb;
        w = w_in;
        bits = '0;
        for (int s = 0; s < steps; s++) begin
            nb = 1'b0;
            for (int i = 0; i < width; i++) if (taps[i]) nb ^= w[width-1-i];
            bits = {bits[6:0], w[0]};
            w = w >> 1;
            w[width-1] = nb;
        end
        w_out = w;
    endfunction

    task automatic model_reset();
        m_w = rev(64'd1, 31); m_dout = 1'b0; m_dv = 1'b0; m_lock = 1'b0; m_ready = 1'b0;
        m7_w = rev(64'd1, 7); m7_dout = '0; m7_dv = 1'b0; m7_lock = 1'b0; m7_ready = 1'b0;
    endtask

    task automatic model_edge();
        logic [7:0] b;
        if (load_valid && m_ready) begin
            if (load_data == '0) begin
                m_w = rev(64'd1, 31);
                m_lock = 1'b1;
            end else begin
                m_w = rev(64'(load_data), 31);
            end
            m_dv = 1'b0;
        end else if (en) begin
            adv(m_w, MT31, 31, 1, m_w, b);
            m_dout = b[0];
            m_dv = 1'b1;
        end else begin
            m_dv = 1'b0;
        end
        m_ready = 1'b1;
        if (en) begin
            adv(m7_w, MT7, 7, 4, m7_w, b);
            m7_dout = b[3:0];
            m7_dv = 1'b1;
        end else begin
            m7_dv = 1'b0;
        end
        m7_ready = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            check("state",      64'(state),      rev(m_w, 31));
            check("dout",       64'(dout),       64'(m_dout));
            check("dout_valid", 64'(dout_valid), 64'(m_dv));
            check("lockup",     64'(lockup),     64'(m_lock));
            check("load_ready", 64'(load_ready), 64'(m_ready));
            check("state7",     64'(state7),     rev(m7_w, 7));
            check("dout7",      64'(dout7),      64'(m7_dout));
            check("dv7",        64'(dv7),        64'(m7_dv));
            check("lock7",      64'(lock7),      64'(m7_lock));
            check("ready7",     64'(ready7),     64'(m7_ready));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

`ifdef PRBS_CHECKER_EN
    logic [63:0] cw;
    task automatic beat(input logic flip);
        logic [7:0] b;
        adv(cw, MT31, 31, 1, cw, b);
        chk_valid = 1'b1;
        chk_in = b[0] ^ flip;
        tick();
        chk_valid = 1'b0;
    endtask
`endif

    initial begin
        logic [39:0] bits31;
        model_reset();
        cmp_on = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("lit_ready_in_reset", 64'(load_ready), 64'd0);
        tick();
        check("lit_ready_after_release", 64'(load_ready), 64'd1);

        // Free run: 31-bit sequence start and PRBS7 period.
        en = 1'b1;
        bits31 = '0;
        for (int c = 1; c <= 254; c++) begin
            tick();
            if (c <= 40) bits31[c-1] = dout[0];
            if (c == 1) check("lit_first_step", 64'(state), 64'h2);
            if (c == 127 || c == 254) check("lit_prbs7_wrap", 64'(state7), 64'h01);
            check("prbs7_nonzero", 64'(state7 != '0), 64'd1);
        end
        check("lit_first30_zero", 64'(bits31[29:0]), 64'd0);
        check("lit_bit31_one", 64'(bits31[30]), 64'd1);

        // Load with en high: load wins, no step.
        load_valid = 1'b1; load_data = 31'h1234_5678;
        tick();
        load_valid = 1'b0;
        check("lit_load_state", 64'(state), 64'h1234_5678);
        check("lit_load_dv", 64'(dout_valid), 64'd0);
        tick();
        check("lit_step_after_load_dv", 64'(dout_valid), 64'd1);

        // Zero load becomes SEED and sets sticky lockup.
        load_valid = 1'b1; load_data = '0;
        tick();
        load_valid = 1'b0;
        check("lit_zero_load_state", 64'(state), 64'd1);
        check("lit_zero_load_lockup", 64'(lockup), 64'd1);
        load_valid = 1'b1; load_data = 31'h7;
        tick();
        load_valid = 1'b0;
        check("lit_lockup_sticky", 64'(lockup), 64'd1);

        // Asynchronous reset mid-operation.
        @(posedge clk);
        model_edge();
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("lit_async_reset_lockup", 64'(lockup), 64'd0);
        check("lit_async_reset_state", 64'(state), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Randomised en / load traffic, including zero seeds.
        for (int c = 0; c < 300; c++) begin
            en = 1'($urandom_range(0, 1));
            load_valid = ($urandom_range(0, 7) == 0);
            load_data = ($urandom_range(0, 3) == 0) ? 31'd0 : 31'($urandom);
            tick();
        end
        load_valid = 1'b0;
        en = 1'b0;

`ifdef PRBS_CHECKER_EN
        cw = rev(64'h1ABC_DEF1, 31);
        for (int i = 0; i < 61; i++) beat(1'b0);
        check("lit_chk_not_locked_61", 64'(chk_locked), 64'd0);
        beat(1'b0);
        check("lit_chk_locked_62", 64'(chk_locked), 64'd1);
        check("lit_chk_errs_0", 64'(chk_errs), 64'd0);
        for (int i = 0; i < 10; i++) beat(1'b0);
        beat(1'b1);
        check("lit_chk_one_err", 64'(chk_errs), 64'd1);
        check("lit_chk_hold_lock", 64'(chk_locked), 64'd1);
        for (int i = 0; i < 5; i++) beat(1'b0);
        for (int i = 0; i < 7; i++) beat(1'b1);
        check("lit_chk_lock_7miss", 64'(chk_locked), 64'd1);
        beat(1'b1);
        check("lit_chk_unlock_8miss", 64'(chk_locked), 64'd0);
        check("lit_chk_errs_9", 64'(chk_errs), 64'd9);
        for (int i = 0; i < 61; i++) beat(1'b0);
        check("lit_chk_relock_61", 64'(chk_locked), 64'd0);
        beat(1'b0);
        check("lit_chk_relock_62", 64'(chk_locked), 64'd1);
        check("lit_chk_errs_kept", 64'(chk_errs), 64'd9);
`endif

        repeat (2) tick();
        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
